// File: rtl/kronos_types.sv
// Shared type definitions for the kronos core and its system glue.
package kronos_types;

    // Arbiter FSM: a grant is issued in IDLE and acknowledged in RESP.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_e;

    // Byte address bit where the SRAM word address begins.
    localparam int ARB_WORD_LSB = 2;

endpackage

// File: rtl/kronos_mem_arbiter.sv
// Two-port (fetch + data) to single-port SRAM arbiter. Data has priority;
// a saturating streak counter lets a waiting fetch through after
// MAX_DATA_STREAK consecutive data grants (0 disables the guard).
module kronos_mem_arbiter
    import kronos_types::*;
#(
    parameter int ADDR_W          = 11,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rstz,

    input  logic [31:0]       instr_addr,
    input  logic              instr_req,
    output logic [31:0]       instr_data,
    output logic              instr_ack,

    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wr_data,
    input  logic [3:0]        data_wr_mask,
    input  logic              data_wr_en,
    input  logic              data_req,
    output logic [31:0]       data_rd_data,
    output logic              data_ack,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              mem_en,
    output logic              mem_wr_en,
    output logic [3:0]        mem_wr_mask
);

    localparam int STREAK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_e          state_q, state_d;
    logic                gnt_data_q, gnt_data_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic in_idle;
    logic instr_turn;
    logic grant_instr;
    logic grant_data;
    logic grant_any;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr[31:ADDR_W+ARB_WORD_LSB], instr_addr[1:0],
                                data_addr[31:ADDR_W+ARB_WORD_LSB],  data_addr[1:0]};

    // Grant decision: data first, unless the fetch has waited out its streak.
    always_comb begin
        in_idle     = (state_q == ARB_IDLE);
        instr_turn  = (MAX_DATA_STREAK > 0) && (streak_q == STREAK_MAX);
        grant_instr = in_idle && instr_req && (!data_req || instr_turn);
        grant_data  = in_idle && data_req && !grant_instr;
        grant_any   = grant_instr || grant_data;
    end

    // Next-state, grant identity and starvation counter.
    always_comb begin
        state_d    = state_q;
        gnt_data_d = gnt_data_q;
        streak_d   = streak_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_any) begin
                    state_d    = ARB_RESP;
                    gnt_data_d = grant_data;
                end
            end
            default: begin
                // Never chain a grant out of RESP: the SRAM read is in flight.
                state_d = ARB_IDLE;
            end
        endcase

        if (grant_instr) begin
            streak_d = '0;
        end else if (grant_data) begin
            if (!instr_req) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q    <= ARB_IDLE;
            gnt_data_q <= 1'b0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_data_q <= gnt_data_d;
            streak_q   <= streak_d;
        end
    end

    // SRAM drive in the grant cycle; strobes are forced low while in reset.
    always_comb begin
        mem_en      = rstz && grant_any;
        mem_wr_en   = rstz && grant_data && data_wr_en;
        mem_wr_mask = (rstz && grant_data) ? data_wr_mask : 4'b0000;
        mem_wdata   = data_wr_data;
        mem_addr    = grant_data ? data_addr[ARB_WORD_LSB +: ADDR_W]
                                 : instr_addr[ARB_WORD_LSB +: ADDR_W];
    end

    // Response: one ack pulse in RESP, read data passed straight through.
    always_comb begin
        instr_ack    = (state_q == ARB_RESP) && !gnt_data_q;
        data_ack     = (state_q == ARB_RESP) && gnt_data_q;
        instr_data   = mem_rdata;
        data_rd_data = mem_rdata;
    end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Directed bench for kronos_mem_arbiter: a vector table for single
// transactions plus hand sequences for reset, contention and priority.
module tb_kronos_mem_arbiter;

    logic clk = 1'b0;
    logic rstz = 1'b0;
    always #5 clk = ~clk;

    // Shared request fields; main DUT (streak 4) and priority DUT (streak 0).
    logic [31:0] instr_addr = '0, data_addr = '0, data_wr_data = '0;
    logic [3:0]  data_wr_mask = '0;
    logic        data_wr_en = 1'b0;
    logic        instr_req = 1'b0, data_req = 1'b0;
    logic        i0_req = 1'b0, d0_req = 1'b0;

    logic [31:0] instr_data, data_rd_data, m_wdata, m_rdata;
    logic        instr_ack, data_ack, m_en, m_wr_en;
    logic [10:0] m_addr;
    logic [3:0]  m_wr_mask;

    logic [31:0] i0_data, d0_data, m0_wdata, m0_rdata;
    logic        i0_ack, d0_ack, m0_en, m0_wr_en;
    logic [10:0] m0_addr;
    logic [3:0]  m0_wr_mask;

    kronos_mem_arbiter #(.ADDR_W(11), .MAX_DATA_STREAK(4)) u_dut (
        .clk(clk), .rstz(rstz),
        .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_data(instr_data), .instr_ack(instr_ack),
        .data_addr(data_addr), .data_wr_data(data_wr_data),
        .data_wr_mask(data_wr_mask), .data_wr_en(data_wr_en),
        .data_req(data_req), .data_rd_data(data_rd_data), .data_ack(data_ack),
        .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_rdata(m_rdata),
        .mem_en(m_en), .mem_wr_en(m_wr_en), .mem_wr_mask(m_wr_mask)
    );

    kronos_mem_arbiter #(.ADDR_W(11), .MAX_DATA_STREAK(0)) u_dut0 (
        .clk(clk), .rstz(rstz),
        .instr_addr(instr_addr), .instr_req(i0_req),
        .instr_data(i0_data), .instr_ack(i0_ack),
        .data_addr(data_addr), .data_wr_data(data_wr_data),
        .data_wr_mask(data_wr_mask), .data_wr_en(1'b0),
        .data_req(d0_req), .data_rd_data(d0_data), .data_ack(d0_ack),
        .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_rdata(m0_rdata),
        .mem_en(m0_en), .mem_wr_en(m0_wr_en), .mem_wr_mask(m0_wr_mask)
    );

    // Synchronous single-port SRAM with byte mask; preloaded on first edge.
    logic [31:0] mem [0:2047];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
            mem[1]  <= 32'h01010101;
            mem[5]  <= 32'hDEADBEEF;
            mem[8]  <= 32'hAAAAAAAA;
            loaded  <= 1'b1;
        end else if (m_en) begin
            if (m_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (m_wr_mask[b]) mem[m_addr][b*8 +: 8] <= m_wdata[b*8 +: 8];
            end
            m_rdata <= mem[m_addr];
        end
    end

    // Minimal read-only memory for the pure-priority instance.
    always @(posedge clk) begin
        if (m0_en) m0_rdata <= {21'h0, m0_addr};
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  mask;
        logic [10:0] exp_addr;
        logic        exp_data;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int n_d, n_i;
        logic exp_d;

        //          ireq dreq iaddr         daddr         wdata         we    mask   addr    data  rd    exp_rd
        vecs[0]  = '{1'b1, 1'b0, 32'h14,       32'h0,        32'h0,        1'b0, 4'h0, 11'd5, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 1'b1, 32'h0,        32'h20,       32'h11223344, 1'b1, 4'h5, 11'd8, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0,        32'h20,       32'h0,        1'b0, 4'h0, 11'd8, 1'b1, 1'b1, 32'hAA22AA44};
        vecs[3]  = '{1'b1, 1'b1, 32'h14,       32'h20,       32'h0,        1'b0, 4'h0, 11'd8, 1'b1, 1'b1, 32'hAA22AA44};
        vecs[4]  = '{1'b0, 1'b1, 32'h0,        32'h2004,     32'h0,        1'b0, 4'h0, 11'd1, 1'b1, 1'b1, 32'h01010101};
        vecs[5]  = '{1'b0, 1'b1, 32'h0,        32'h0C,       32'hCAFEF00D, 1'b1, 4'hF, 11'd3, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0C,       32'h0,        32'h0,        1'b0, 4'h0, 11'd3, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[7]  = '{1'b1, 1'b0, 32'h17,       32'h0,        32'h0,        1'b0, 4'h0, 11'd5, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 1'b1, 32'h0,        32'hFFFFE008, 32'h55000000, 1'b1, 4'h8, 11'd2, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0,        32'h08,       32'h0,        1'b0, 4'h0, 11'd2, 1'b1, 1'b1, 32'h55000000};
        vecs[10] = '{1'b0, 1'b1, 32'h0,        32'h08,       32'h0,        1'b0, 4'h0, 11'd2, 1'b1, 1'b1, 32'h55000000};

        // ---- Reset with both requests high: strobes forced low, no acks.
        instr_req = 1'b1; data_req = 1'b1; i0_req = 1'b1; d0_req = 1'b1;
        data_wr_en = 1'b1; data_wr_mask = 4'hF; data_addr = 32'h40; instr_addr = 32'h14;
        repeat (2) @(negedge clk);
        chk("rst_mem_en",    32'(m_en), 32'h0);
        chk("rst_wr_en",     32'(m_wr_en), 32'h0);
        chk("rst_wr_mask",   32'(m_wr_mask), 32'h0);
        chk("rst_acks",      32'({instr_ack, data_ack}), 32'h0);
        chk("rst0_mem_en",   32'(m0_en), 32'h0);
        i0_req = 1'b0; d0_req = 1'b0;
        @(posedge clk); #1 rstz = 1'b1;
        @(negedge clk);
        chk("first_gnt_en",   32'(m_en), 32'h1);
        chk("first_gnt_data", 32'(m_wr_en), 32'h1);
        chk("first_gnt_addr", 32'(m_addr), 32'd16);
        @(negedge clk);
        chk("first_data_ack",  32'(data_ack), 32'h1);
        chk("first_instr_ack", 32'(instr_ack), 32'h0);
        $display("reset: first grant after release data_ack=%0b", data_ack);
        instr_req = 1'b0; data_req = 1'b0; data_wr_en = 1'b0; data_wr_mask = 4'h0;

        // ---- Table of single transactions.
        for (int v = 0; v < 11; v++) begin
            @(posedge clk); #1;
            instr_req = vecs[v].ireq; data_req = vecs[v].dreq;
            instr_addr = vecs[v].iaddr; data_addr = vecs[v].daddr;
            data_wr_data = vecs[v].wdata; data_wr_en = vecs[v].we;
            data_wr_mask = vecs[v].mask;
            @(negedge clk);
            chk($sformatf("v%0d_mem_en", v),   32'(m_en), 32'h1);
            chk($sformatf("v%0d_mem_addr", v), 32'(m_addr), 32'(vecs[v].exp_addr));
            chk($sformatf("v%0d_wr_en", v),    32'(m_wr_en), 32'(vecs[v].exp_data & vecs[v].we));
            chk($sformatf("v%0d_wr_mask", v),  32'(m_wr_mask), vecs[v].exp_data ? 32'(vecs[v].mask) : 32'h0);
            chk($sformatf("v%0d_early_ack", v), 32'({instr_ack, data_ack}), 32'h0);
            @(negedge clk);
            chk($sformatf("v%0d_data_ack", v),  32'(data_ack), 32'(vecs[v].exp_data));
            chk($sformatf("v%0d_instr_ack", v), 32'(instr_ack), 32'(!vecs[v].exp_data));
            chk($sformatf("v%0d_resp_en", v),   32'(m_en), 32'h0);
            if (vecs[v].chk_rd)
                chk($sformatf("v%0d_rdata", v),
                    vecs[v].exp_data ? data_rd_data : instr_data, vecs[v].exp_rd);
            $display("vec %0d: addr=%0d wr=%0b data_ack=%0b instr_ack=%0b rdata=%h",
                     v, m_addr, m_wr_en, data_ack, instr_ack, data_rd_data);
            instr_req = 1'b0; data_req = 1'b0; data_wr_en = 1'b0; data_wr_mask = 4'h0;
        end

        // ---- Contention with streak guard: D,D,D,D,I repeating.
        @(posedge clk); #1;
        instr_addr = 32'h14; data_addr = 32'h20; instr_req = 1'b1; data_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk($sformatf("cont%0d_grant_en", k), 32'(m_en), 32'h1);
                chk($sformatf("cont%0d_no_ack", k), 32'({instr_ack, data_ack}), 32'h0);
            end else begin
                exp_d = ((k / 2) % 5) != 4;
                chk($sformatf("cont%0d_acks", k), 32'({instr_ack, data_ack}), exp_d ? 32'h1 : 32'h2);
                $display("contention grant %0d: %s", k / 2, data_ack ? "D" : (instr_ack ? "I" : "-"));
            end
        end
        instr_req = 1'b0; data_req = 1'b0;

        // ---- Pure data priority on the streak-0 instance.
        @(posedge clk); #1;
        i0_req = 1'b1; d0_req = 1'b1;
        n_d = 0; n_i = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (d0_ack) n_d++;
            if (i0_ack) n_i++;
        end
        i0_req = 1'b0; d0_req = 1'b0;
        chk("prio_data_acks",  32'(n_d), 32'd20);
        chk("prio_instr_acks", 32'(n_i), 32'd0);
        $display("priority: data_acks=%0d instr_acks=%0d", n_d, n_i);

        // ---- Reset in RESP drops the ack; held request re-runs afterwards.
        @(posedge clk); #1;
        data_addr = 32'h20; data_req = 1'b1;
        @(negedge clk);
        chk("rmid_grant_en", 32'(m_en), 32'h1);
        @(posedge clk); #1 rstz = 1'b0;
        @(negedge clk);
        chk("rmid_ack_dropped", 32'(data_ack), 32'h0);
        chk("rmid_mem_en",      32'(m_en), 32'h0);
        @(posedge clk); #1 rstz = 1'b1;
        @(negedge clk);
        chk("rmid_regrant_no_ack", 32'(data_ack), 32'h0);
        chk("rmid_regrant_en",     32'(m_en), 32'h1);
        @(negedge clk);
        chk("rmid_ack",   32'(data_ack), 32'h1);
        chk("rmid_rdata", data_rd_data, 32'hAA22AA44);
        $display("reset mid-op: ack after release data_ack=%0b rdata=%h", data_ack, data_rd_data);
        data_req = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kronos_mem_arbiter.md
# kronos_mem_arbiter

- Two-port to single-port memory arbiter between `kronos_core` and one synchronous single-port SRAM of the `spsram32_model` kind.
- Accepts the core's instruction-fetch and data request/ack ports and serialises them onto one SRAM port.
- Data accesses have priority, with a bounded-starvation guard for instruction fetch.
- Returns read data with a one-cycle ack pulse; this replaces ad-hoc combinational muxing in system tops and benches.

## Interface

Parameters:
- `ADDR_W`, default 11: SRAM word-address width; depth is `2**ADDR_W` words.
- `MAX_DATA_STREAK`, default 4: maximum consecutive data grants while an instruction request is pending; 0 means pure data priority.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `rstz` in 1: asynchronous, active-low reset.
- `instr_addr` in 32: fetch byte address.
- `instr_req` in 1: fetch request.
- `instr_data` out 32: fetch read data.
- `instr_ack` out 1: fetch ack pulse.
- `data_addr` in 32: load/store byte address.
- `data_wr_data` in 32: store data.
- `data_wr_mask` in 4: byte-lane write enables.
- `data_wr_en` in 1: 1 = store, 0 = load.
- `data_req` in 1: data request.
- `data_rd_data` out 32: load data.
- `data_ack` out 1: data ack pulse.
- `mem_addr` out ADDR_W: SRAM word address.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: SRAM read data, valid the cycle after `mem_en`.
- `mem_en` out 1: SRAM access enable.
- `mem_wr_en` out 1: SRAM write enable.
- `mem_wr_mask` out 4: SRAM byte mask.

## Operation

States: IDLE, RESP.

IDLE:
- If no request is pending, stay in IDLE with `mem_en` = 0.
- Otherwise grant one requester:
  - Data wins, unless `instr_req` is high and `streak == MAX_DATA_STREAK` with `MAX_DATA_STREAK > 0`; then instruction wins.
- In the grant cycle (combinational from the granted port):
  - `mem_en` = 1.
  - `mem_addr` = `addr[2 +: ADDR_W]`.
  - For a data grant: `mem_wr_en` = `data_wr_en`, `mem_wdata` = `data_wr_data`, `mem_wr_mask` = `data_wr_mask`.
  - For an instruction grant: `mem_wr_en` = 0 and `mem_wr_mask` = 0.
- Register the grant identity (`gnt_data`) and move to RESP.

RESP:
- Assert exactly one of `instr_ack` / `data_ack` according to `gnt_data`.
- `instr_data` and `data_rd_data` both carry `mem_rdata` unconditionally; they are meaningful only with their ack.
- A store also acks in RESP; its read-data content is don't-care.
- `mem_en` = 0. Always return to IDLE; no new grant is issued in RESP.

Starvation counter `streak`, width `$clog2(MAX_DATA_STREAK+1)`, minimum 1:
- Increment on a data grant made while `instr_req` = 1; saturate at `MAX_DATA_STREAK`.
- Clear on any instruction grant, and on a data grant made with `instr_req` = 0.

Address handling:
- Address bits 1:0 are ignored.
- Address bits above `ADDR_W+1` are dropped, so out-of-range addresses alias.

Requester obligations:
- Hold `req` and all request fields stable until the ack.
- Deassert `req`, or present a new request, in the cycle after the ack.
- The arbiter samples request fields only in the grant cycle.

## Timing

- Reset (`rstz` low, asynchronous):
  - State = IDLE, `gnt_data` = 0, `streak` = 0.
  - `instr_ack` = `data_ack` = 0.
  - `mem_en` = `mem_wr_en` = 0 and `mem_wr_mask` = 0, forced low regardless of request inputs.
  - `mem_addr` and `mem_wdata` are don't-care.
- Latency: request seen in grant cycle N produces ack in cycle N+1. Peak throughput is one access per 2 cycles.
- Back-to-back: a request held high after its ack is treated as a new request in cycle N+2.
- Simultaneous `instr_req` and `data_req`:
  - Data is granted, subject to the streak rule.
  - The loser waits with no ack and is re-arbitrated in the next IDLE cycle.
- A request that rises during RESP is first considered in the following IDLE cycle.
- Reset asserted in RESP drops the pending ack. Reset asserted mid-write leaves SRAM content undefined for that word only if reset coincides with the grant edge.

## Structure

- `kronos_types` gains `typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_e`.
- Single module, no sub-modules. The `MAX_DATA_STREAK` saturating counter is inline.
- Benches instantiate the arbiter with `spsram32_model` clocked on `clk`, not on the inverted clock.

## Test plan

- Reset/idle: `rstz` = 0 with both reqs high. Then `mem_en` = 0 and both acks = 0. After release, the first grant is to data.
- Single fetch: mem word 5 = `32'hDEADBEEF`, `instr_addr` = `32'h14`. Then `mem_en` = 1 with `mem_addr` = 5 in cycle N, and `instr_ack` = 1 with `instr_data` = `32'hDEADBEEF` in N+1.
- Masked store then load:
  - Store `data_addr` = `32'h20`, `wdata` = `32'h11223344`, mask = `4'b0101` over old word `32'hAAAAAAAA`.
  - Then load the same address.
  - `data_rd_data` = `32'hAA22AA44`, and `instr_ack` is never asserted.
- Contention, `MAX_DATA_STREAK` = 4:
  - Hold both reqs continuously.
  - Grant order is D,D,D,D,I,D,D,D,D,I…, with acks every second cycle.
- Pure priority, `MAX_DATA_STREAK` = 0: with both reqs held for 40 cycles, `instr_ack` stays 0 and there are 20 `data_ack` pulses.
- Aliasing and reset mid-op:
  - `data_addr` = `32'h0000_2004` with `ADDR_W` = 11 gives `mem_addr` = 1.
  - Asserting `rstz` low in RESP suppresses the ack, and the next request is acked 2 cycles after reset release.
